// File: rtl/downcnt_pkg.sv
// Shared types and constants for the down-counter timer controller.
package downcnt_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/downcnt_timer_ctrl_if.sv
// Consumer-facing handshake and status bundle of the timer controller.
interface downcnt_timer_ctrl_if
   import downcnt_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             mode;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             cnt_en;
   logic             busy;
   logic             done;
   logic             tc;

   modport master (
      output start, load_val, mode, pause, abort,
      input  count, cnt_en, busy, done, tc
   );

   modport slave (
      input  start, load_val, mode, pause, abort,
      output count, cnt_en, busy, done, tc
   );

endinterface

// File: rtl/down_cnt_ld.sv
// Loadable synchronous down counter built from toggle stages.
module down_cnt_ld #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] tog;

   // A stage toggles when enabled and every lower stage is zero (borrow ripple).
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      if (i == 0) begin : g_lsb
         assign tog[i] = en;
      end else begin : g_upper
         assign tog[i] = en && (q[i-1:0] == '0);
      end
   end

   // Load has priority over counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (ld) begin
         q <= d;
      end else begin
         q <= q ^ tog;
      end
   end

endmodule

// File: rtl/downcnt_timer_ctrl.sv
// Sequencing controller: load, gate, terminal-count detect, one-shot or reload.
module downcnt_timer_ctrl
   import downcnt_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   downcnt_timer_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             tc_q, tc_d;
   logic             busy_q, done_q;
   logic             cnt_en_c;
   logic             cnt_ld;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   down_cnt_ld #(.WIDTH(WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (cnt_en_c),
      .ld  (cnt_ld),
      .d   (cnt_d),
      .q   (cnt_q)
   );

   assign bus.count  = cnt_q;
   assign bus.cnt_en = cnt_en_c;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.tc     = tc_q;

   // State, captured start parameters and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         reload_q <= '0;
         mode_q   <= MODE_ONESHOT;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         tc_q     <= tc_d;
         busy_q   <= (state_d == RUN);
         done_q   <= (state_d == DONE);
      end
   end

   // Next state, counter load/enable and terminal-count pulse.
   always_comb begin
      state_d  = state_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_d     = 1'b0;
      cnt_ld   = 1'b0;
      cnt_d    = '0;
      cnt_en_c = (state_q == RUN) && !bus.pause;

      if (bus.abort) begin
         state_d = IDLE;
         cnt_ld  = 1'b1;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  cnt_ld   = 1'b1;
                  cnt_d    = bus.load_val;
                  reload_d = bus.load_val;
                  mode_d   = bus.mode;
                  if (bus.load_val == '0) begin
                     state_d = DONE;
                     tc_d    = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (!bus.pause) begin
                  if (cnt_q == '0) begin
                     // Only reachable in auto-reload; reload instead of wrapping.
                     cnt_ld = 1'b1;
                     cnt_d  = reload_q;
                  end else if (cnt_q == WIDTH'(1)) begin
                     tc_d = 1'b1;
                     if (mode_q == MODE_ONESHOT) begin
                        state_d = DONE;
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_ld  = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_downcnt_timer_ctrl.sv
// Self-checking bench for downcnt_timer_ctrl: per-cycle model compare plus directed literals.
module tb_downcnt_timer_ctrl;

   logic clk = 1'b0;
   logic rst;

   int total  = 0;
   int passed = 0;

   // Behavioural model of the observable timer behaviour.
   bit m_run    = 1'b0;
   bit m_done   = 1'b0;
   bit m_tc     = 1'b0;
   bit m_auto   = 1'b0;
   int m_count  = 0;
   int m_reload = 0;

   downcnt_timer_ctrl_if #(.WIDTH(4)) bus ();

   downcnt_timer_ctrl #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Advance the model on each edge, then compare every DUT output shortly after.
   always @(posedge clk) begin
      m_tc = 1'b0;
      if (rst) begin
         m_run = 0; m_done = 0; m_count = 0; m_reload = 0; m_auto = 0;
      end else if (bus.abort) begin
         m_run = 0; m_done = 0; m_count = 0;
      end else if (!m_run && bus.start) begin
         m_reload = int'(bus.load_val);
         m_auto   = bus.mode;
         if (bus.load_val == 4'd0) begin
            m_count = 0; m_done = 1; m_tc = 1;
         end else begin
            m_count = int'(bus.load_val); m_run = 1; m_done = 0;
         end
      end else if (m_run && !bus.pause) begin
         if (m_count == 0) begin
            m_count = m_reload;
         end else begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_tc = 1;
               if (!m_auto) begin
                  m_run = 0; m_done = 1;
               end
            end
         end
      end
      #1;
      check("model_count",  int'(bus.count),  m_count);
      check("model_busy",   int'(bus.busy),   int'(m_run));
      check("model_done",   int'(bus.done),   int'(m_done));
      check("model_tc",     int'(bus.tc),     int'(m_tc));
      check("model_cnt_en", int'(bus.cnt_en), int'(m_run && !bus.pause));
   end

   initial begin
      int tcs;
      int dns;
      rst = 1'b1;
      bus.start = 1'b0; bus.load_val = 4'd0; bus.mode = 1'b0;
      bus.pause = 1'b0; bus.abort = 1'b0;

      // Reset for two cycles
      tick(); tick();
      check("rst_count",  int'(bus.count),  0);
      check("rst_busy",   int'(bus.busy),   0);
      check("rst_done",   int'(bus.done),   0);
      check("rst_tc",     int'(bus.tc),     0);
      check("rst_cnt_en", int'(bus.cnt_en), 0);
      rst = 1'b0;

      // One-shot of 5
      bus.start = 1'b1; bus.load_val = 4'd5; bus.mode = 1'b0;
      tick();
      check("os_first_count", int'(bus.count), 5);
      check("os_first_busy",  int'(bus.busy),  1);
      bus.start = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         tick();
         check("os_count", int'(bus.count), i);
      end
      check("os_tc",   int'(bus.tc),   1);
      check("os_done", int'(bus.done), 1);
      check("os_busy", int'(bus.busy), 0);
      tick();
      check("os_tc_drop",  int'(bus.tc),   0);
      check("os_done_hold", int'(bus.done), 1);

      // Auto-reload of 3 from DONE
      bus.start = 1'b1; bus.load_val = 4'd3; bus.mode = 1'b1;
      tick();
      check("ar_first_count", int'(bus.count), 3);
      check("ar_done_drop",   int'(bus.done),  0);
      bus.start = 1'b0;
      tcs = 0; dns = 0;
      for (int j = 1; j <= 12; j++) begin
         tick();
         check("ar_count", int'(bus.count), 3 - (j % 4));
         if (bus.tc) tcs++;
         if (bus.done) dns++;
      end
      check("ar_tc_pulses", tcs, 3);
      check("ar_done_seen", dns, 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("ar_abort_count", int'(bus.count), 0);
      check("ar_abort_busy",  int'(bus.busy),  0);

      // One-shot of 4 with a 3-cycle pause at count 2
      bus.start = 1'b1; bus.load_val = 4'd4; bus.mode = 1'b0;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      check("pz_at2", int'(bus.count), 2);
      bus.pause = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("pz_hold",   int'(bus.count),  2);
         check("pz_cnt_en", int'(bus.cnt_en), 0);
      end
      bus.pause = 1'b0;
      tick();
      check("pz_after1", int'(bus.count), 1);
      tick();
      check("pz_done", int'(bus.done), 1);
      check("pz_tc",   int'(bus.tc),   1);

      // Ignored start in RUN, then abort
      bus.start = 1'b1; bus.load_val = 4'd9; bus.mode = 1'b0;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick();
      check("ig_at6", int'(bus.count), 6);
      bus.start = 1'b1; bus.load_val = 4'd2; bus.mode = 1'b1;
      tick();
      bus.start = 1'b0;
      check("ig_count5", int'(bus.count), 5);
      tick();
      check("ig_count4", int'(bus.count), 4);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("ab_count", int'(bus.count), 0);
      check("ab_busy",  int'(bus.busy),  0);
      check("ab_done",  int'(bus.done),  0);
      check("ab_tc",    int'(bus.tc),    0);

      // Zero load goes straight to DONE with a tc
      bus.start = 1'b1; bus.load_val = 4'd0; bus.mode = 1'b0;
      tick();
      bus.start = 1'b0;
      check("z_done", int'(bus.done), 1);
      check("z_tc",   int'(bus.tc),   1);
      check("z_busy", int'(bus.busy), 0);

      // Full-scale load from DONE, no wrap
      bus.start = 1'b1; bus.load_val = 4'd15; bus.mode = 1'b0;
      tick();
      bus.start = 1'b0;
      check("f_count15", int'(bus.count), 15);
      check("f_busy",    int'(bus.busy),  1);
      tcs = 0;
      for (int i = 14; i >= 0; i--) begin
         tick();
         check("f_count", int'(bus.count), i);
         if (bus.tc) tcs++;
      end
      check("f_tc_once", tcs, 1);
      check("f_done",    int'(bus.done), 1);

      // Reset concurrent with start
      rst = 1'b1;
      bus.start = 1'b1; bus.load_val = 4'd7; bus.mode = 1'b1;
      tick();
      rst = 1'b0; bus.start = 1'b0;
      check("rs_count", int'(bus.count), 0);
      check("rs_busy",  int'(bus.busy),  0);
      check("rs_done",  int'(bus.done),  0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/downcnt_timer_ctrl.md
# downcnt_timer_ctrl

Sequencing controller for the synchronous down counter: loads a start value, gates the counter's toggle enable, detects terminal count and either stops (one-shot) or reloads (auto-reload). Provides a start/busy/done handshake plus pause and abort. The controller is the single owner of the counter's enable and load path. It sits between timing consumers and the shared 4-bit down-counter datapath.

## Interface
Parameters:
- WIDTH, 4, counter width in bits

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; request a new countdown (honoured in IDLE or DONE only)
- load_val  in  WIDTH  start value, sampled only on an honoured start
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled with load_val
- pause  in  1  level; while high in RUN, count holds
- abort  in  1  pulse; return to IDLE from any state
- count  out  WIDTH  current counter value (registered)
- cnt_en  out  1  toggle/decrement enable driven to the datapath (combinational from state and pause)
- busy  out  1  high in RUN
- done  out  1  level, high in DONE
- tc  out  1  one-cycle pulse, registered, asserted in the cycle count first becomes 0

## Operation
- States:
  - IDLE: count=0, busy=0, done=0.
  - RUN.
  - DONE: done=1, count=0.
- Internal registers: reload_reg (WIDTH), mode_reg.
- IDLE/DONE + start:
  - Capture load_val into count and reload_reg; capture mode into mode_reg.
  - load_val≠0 → RUN.
  - load_val=0 → DONE with tc=1 in the following cycle.
- RUN, pause=0 (cnt_en=1):
  - count>1 → count−1.
  - count=1 → count=0 and tc=1; mode_reg=0 → DONE, mode_reg=1 → stay in RUN.
  - count=0 (auto-reload only) → count=reload_reg, no tc.
- RUN, pause=1: cnt_en=0; count, state and tc source all hold; no tc is generated while paused.
- Auto-reload period is reload_reg+1 cycles per tc.
- start while in RUN is ignored: no restart, and load_val/mode are not sampled.
- Priority, highest first: rst, then abort, then start, then pause, then count.
- abort: next cycle IDLE, count=0, tc=0, busy=0, done=0.
- Arithmetic is unsigned, WIDTH bits. Count never wraps below 0: the 0 → all-ones transition is illegal, and count returns to 0 only via reload or state change.

## Timing
- Reset values: count=0, busy=0, done=0, tc=0, cnt_en=0; state=IDLE; reload_reg=0; mode_reg=0.
- start sampled at edge k with load_val=N (N≥1):
  - After edge k: busy=1, count=N.
  - After edge k+N: count=0, tc=1 for exactly one cycle.
  - One-shot: done=1 and busy=0 after edge k+N.
- Each pause cycle in RUN extends the above by one cycle.
- start in DONE at edge k: done drops and busy rises after edge k. There are no idle cycles between back-to-back one-shots.
- rst asserted mid-count: all outputs reach reset values after the next edge, regardless of other inputs.
- tc and done never both rise in different cycles for the same one-shot expiry; they rise together.

## Structure
- Shared package downcnt_pkg:
  - State typedef: IDLE, RUN, DONE, 2-bit encoding.
  - Default WIDTH constant.
  - Mode constants MODE_ONESHOT=0, MODE_RELOAD=1.
- One sub-module: down_cnt_ld, the WIDTH-bit synchronous down counter built from T-FF stages.
  - Ports: clk, rst, en, ld, d, q.
  - ld has priority over en.
- The controller instantiates down_cnt_ld, drives en=cnt_en and ld/d for load and reload, and contains only the FSM, reload_reg/mode_reg and tc generation. Target 150–250 lines total.

## Test plan
- Reset, then one-shot: rst 2 cycles, start with load_val=5, mode=0 → count 5,4,3,2,1,0 on successive cycles; tc and done rise at count=0; busy low 5 cycles after start; done held.
- Auto-reload: load_val=3, mode=1, run 12 cycles → count 3,2,1,0,3,2,1,0,…; tc exactly once every 4 cycles; done never asserts.
- Pause: load_val=4, one-shot, pause high for 3 cycles while count=2 → count holds at 2, cnt_en=0; done arrives 7 cycles after start; no extra tc.
- Abort and ignored start: load_val=9; at count=6 pulse start with load_val=2 → ignored, count continues 5,4; then abort → next cycle IDLE, count=0, busy=0, no tc.
- Corners: start with load_val=0 → DONE next cycle with tc=1. start with load_val=15 at WIDTH=4 → 15 cycles to tc, no wrap. start in DONE → immediate RUN. rst concurrent with start → IDLE, count=0.
